dsp_mem_stage: RTL

Parametrised memory/write-back stage for the DSP receiver datapath, sitting between execute and the register file. It decodes the per-instruction memory mode, steers loads and stores to one of `BANKS` single-port SRAM banks selected by upper address bits, and waits a configurable SRAM read latency. It returns a registered, tagged write-back to the register file. It replaces the combinational, clock-phase-gated memory logic with fully synchronous enables and a valid/ready handshake toward execute.

---
 rtl/dsp_mem_stage_if.sv | 47 ++++
 rtl/dsp_mem_stage.sv | 118 +++++++++++
 2 files changed

// File: rtl/dsp_mem_stage_if.sv
// Bundle of the execute-side handshake, SRAM bank bus and register-file
// write-back port of the DSP memory/write-back stage.
interface dsp_mem_stage_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int BANKS  = 2,
    parameter int REG_W  = 4
);
    // Execute side
    logic                    in_valid;
    logic                    in_ready;
    logic [2:0]              mem_mode;
    logic [DATA_W-1:0]       data_s1;
    logic [DATA_W-1:0]       data_s2;
    logic [DATA_W-1:0]       alu_result;
    logic                    wb_en_in;
    logic [REG_W-1:0]        wb_reg_in;

    // SRAM banks
    logic [ADDR_W-1:0]       mem_addr;
    logic [BANKS-1:0]        mem_rd_en;
    logic [BANKS-1:0]        mem_wr_en;
    logic [DATA_W-1:0]       mem_wdata;
    logic [BANKS*DATA_W-1:0] mem_rdata;

    // Register-file write-back
    logic                    wb_valid;
    logic [REG_W-1:0]        wb_reg;
    logic [DATA_W-1:0]       wb_data;
    logic                    mode_err;

    // The memory stage itself
    modport slave (
        input  in_valid, mem_mode, data_s1, data_s2, alu_result,
               wb_en_in, wb_reg_in, mem_rdata,
        output in_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
               wb_valid, wb_reg, wb_data, mode_err
    );

    // Whoever drives execute requests and owns the SRAM banks
    modport master (
        output in_valid, mem_mode, data_s1, data_s2, alu_result,
               wb_en_in, wb_reg_in, mem_rdata,
        input  in_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
               wb_valid, wb_reg, wb_data, mode_err
    );
endinterface

// File: rtl/dsp_mem_stage.sv
// Memory/write-back stage: decodes the memory mode, steers loads and stores
// to one of BANKS single-port SRAM banks, waits out the SRAM read latency
// and returns a registered, tagged write-back to the register file.
module dsp_mem_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int BANKS  = 2,
    parameter int RD_LAT = 1,
    parameter int REG_W  = 4
) (
    input logic            clk,
    input logic            rst,
    dsp_mem_stage_if.slave bus
);
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int CNT_W  = 3;

    localparam logic [2:0] MODE_NONE   = 3'd0;
    localparam logic [2:0] MODE_LD     = 3'd1;
    localparam logic [2:0] MODE_ST     = 3'd2;
    localparam logic [2:0] MODE_LD_IMM = 3'd3;

    typedef enum logic {IDLE, LD_WAIT} state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [BANK_W-1:0] ld_bank;
    logic [REG_W-1:0]  ld_reg;
    logic [BANK_W-1:0] bank_sel;
    logic              accept;
    logic [DATA_W-1:0] ld_rdata;

    // Upper address bits pick the bank; a single bank needs no select bits
    generate
        if (BANKS == 1) begin : g_one_bank
            assign bank_sel = '0;
        end else begin : g_multi_bank
            assign bank_sel = bus.data_s1[DATA_W-1 -: BANK_W];
        end
    endgenerate

    assign accept        = bus.in_valid && (state == IDLE);
    assign bus.in_ready  = (state == IDLE);
    assign bus.mem_addr  = bus.data_s1[ADDR_W-1:0];
    assign bus.mem_wdata = bus.data_s2;
    assign ld_rdata      = bus.mem_rdata[int'(ld_bank) * DATA_W +: DATA_W];

    // One-hot bank strobes, only in the cycle an instruction is accepted
    always_comb begin
        bus.mem_rd_en = '0;
        bus.mem_wr_en = '0;
        if (accept && (bus.mem_mode == MODE_LD)) begin
            bus.mem_rd_en[bank_sel] = 1'b1;
        end
        if (accept && (bus.mem_mode == MODE_ST)) begin
            bus.mem_wr_en[bank_sel] = 1'b1;
        end
    end

    // Stage control: immediate write-backs from IDLE, latency countdown for loads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            ld_bank      <= '0;
            ld_reg       <= '0;
            bus.wb_valid <= 1'b0;
            bus.wb_data  <= '0;
            bus.wb_reg   <= '0;
            bus.mode_err <= 1'b0;
        end else begin
            bus.wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        case (bus.mem_mode)
                            MODE_NONE: begin
                                if (bus.wb_en_in) begin
                                    bus.wb_valid <= 1'b1;
                                    bus.wb_data  <= bus.alu_result;
                                    bus.wb_reg   <= bus.wb_reg_in;
                                end
                            end
                            MODE_LD_IMM: begin
                                bus.wb_valid <= 1'b1;
                                bus.wb_data  <= bus.data_s1;
                                bus.wb_reg   <= bus.wb_reg_in;
                            end
                            MODE_ST: begin
                            end
                            MODE_LD: begin
                                ld_bank <= bank_sel;
                                ld_reg  <= bus.wb_reg_in;
                                count   <= CNT_W'(RD_LAT);
                                state   <= LD_WAIT;
                            end
                            default: begin
                                bus.mode_err <= 1'b1;
                            end
                        endcase
                    end
                end
                LD_WAIT: begin
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        bus.wb_valid <= 1'b1;
                        bus.wb_data  <= ld_rdata;
                        bus.wb_reg   <= ld_reg;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
